// File: rtl/s15850_n460_scan_drv.sv
// Scan/state driver for the s15850 n460 cone: accepts a 20-bit pattern, shifts it into the chain,
// captures n460 and returns it. Optional signature register built when S15850_N460_MISR_EN is defined.
module s15850_n460_scan_drv #(
    parameter int                 CNT_W     = 16,
    parameter int                 MISR_W    = 16,
    parameter logic [MISR_W-1:0]  MISR_POLY = 16'hB400
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              pat_valid,
    output logic              pat_ready,
    input  logic [19:0]       pat_data,
    output logic [19:0]       state_q,
    output logic              cone_valid,
    output logic              so,
    input  logic              n460,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_bit,
    output logic [CNT_W-1:0]  pat_cnt,
    output logic [MISR_W-1:0] sig,
    input  logic              sig_clr
);

    localparam int NBITS = 20;

    // Handshakes: a transfer happens on a rising CK edge where valid and ready are both high;
    // the sender holds valid and data stable until that edge.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } fsm_e;

    fsm_e               fsm_q, fsm_d;
    logic [NBITS-1:0]   shadow_q, shadow_d;
    logic [NBITS-1:0]   state_d;
    logic [4:0]         k_q, k_d;
    logic               res_bit_q, res_bit_d;
    logic [CNT_W-1:0]   pat_cnt_q, pat_cnt_d;
    logic               pat_ready_q, pat_ready_d;
    logic               cone_valid_q, cone_valid_d;
    logic               res_valid_q, res_valid_d;

    always_comb begin
        fsm_d     = fsm_q;
        shadow_d  = shadow_q;
        state_d   = state_q;
        k_d       = k_q;
        res_bit_d = res_bit_q;
        pat_cnt_d = pat_cnt_q;
        case (fsm_q)
            ST_IDLE: begin
                if (pat_valid && pat_ready_q) begin
                    shadow_d = pat_data;
                    k_d      = 5'd0;
                    fsm_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Bit k enters at the top; after NBITS shifts shadow[0] has reached chain[0].
                state_d = {shadow_q[k_q], state_q[NBITS-1:1]};
                if (k_q == 5'(NBITS - 1)) begin
                    k_d   = 5'd0;
                    fsm_d = ST_SETTLE;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            ST_SETTLE: begin
                fsm_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                res_bit_d = n460;
                if (pat_cnt_q != {CNT_W{1'b1}}) begin
                    pat_cnt_d = pat_cnt_q + 1'b1;
                end
                fsm_d = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready && res_valid_q) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase

        // Flag outputs are registered from the next state so they line up with fsm_q.
        pat_ready_d  = (fsm_d == ST_IDLE);
        cone_valid_d = (fsm_d == ST_SETTLE) || (fsm_d == ST_CAPTURE) || (fsm_d == ST_RESP);
        res_valid_d  = (fsm_d == ST_RESP);
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            fsm_q        <= ST_IDLE;
            shadow_q     <= '0;
            state_q      <= '0;
            k_q          <= 5'd0;
            res_bit_q    <= 1'b0;
            pat_cnt_q    <= '0;
            pat_ready_q  <= 1'b0;
            cone_valid_q <= 1'b0;
            res_valid_q  <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            shadow_q     <= shadow_d;
            state_q      <= state_d;
            k_q          <= k_d;
            res_bit_q    <= res_bit_d;
            pat_cnt_q    <= pat_cnt_d;
            pat_ready_q  <= pat_ready_d;
            cone_valid_q <= cone_valid_d;
            res_valid_q  <= res_valid_d;
        end
    end

    assign pat_ready  = pat_ready_q;
    assign cone_valid = cone_valid_q;
    assign res_valid  = res_valid_q;
    assign res_bit    = res_bit_q;
    assign pat_cnt    = pat_cnt_q;
    assign so         = state_q[0];

`ifdef S15850_N460_MISR_EN
    logic [MISR_W-1:0] sig_q, sig_d;

    // Galois MISR folding n460 into the LSB; an explicit clear beats a same-cycle capture.
    always_comb begin
        sig_d = sig_q;
        if (sig_clr) begin
            sig_d = '0;
        end else if (fsm_q == ST_CAPTURE) begin
            sig_d = {sig_q[MISR_W-2:0], 1'b0}
                  ^ (sig_q[MISR_W-1] ? MISR_POLY : {MISR_W{1'b0}})
                  ^ {{(MISR_W-1){1'b0}}, n460};
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`else
    logic unused_misr;
    assign unused_misr = &{1'b0, sig_clr, MISR_POLY};
    assign sig         = '0;
`endif

endmodule

// File: tb/tb_s15850_n460_scan_drv.sv
// Bench for s15850_n460_scan_drv: drives patterns through a parity cone model and checks
// latency, scan-out, result, counter, signature, backpressure and reset against a reference model.
module tb_s15850_n460_scan_drv;

  logic        CK;
  logic        RST;
  logic        pat_valid;
  logic        pat_ready;
  logic [19:0] pat_data;
  logic [19:0] state_q;
  logic        cone_valid;
  logic        so;
  logic        n460;
  logic        res_valid;
  logic        res_ready;
  logic        res_bit;
  logic [15:0] pat_cnt;
  logic [15:0] sig;
  logic        sig_clr;

  int vectors = 0;
  int errors  = 0;

  // reference model state
  logic [19:0] exp_chain;
  logic [15:0] exp_cnt;
  logic [15:0] exp_sig;
  logic [15:0] exp_q[$];

  s15850_n460_scan_drv dut (
    .CK(CK), .RST(RST), .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_data(pat_data),
    .state_q(state_q), .cone_valid(cone_valid), .so(so), .n460(n460), .res_valid(res_valid),
    .res_ready(res_ready), .res_bit(res_bit), .pat_cnt(pat_cnt), .sig(sig), .sig_clr(sig_clr)
  );

  // cone stand-in: parity of all twenty state bits
  assign n460 = ^state_q;

  initial CK = 1'b0;
  always #5 CK = ~CK;

  function automatic logic [15:0] sig_model(input logic [15:0] s, input logic b);
    int v;
    v = (int'(s) * 2) % 65536;
    if (s >= 16'h8000) v = v ^ 32'h0000B400;
    v = v ^ int'(b);
    return v[15:0];
  endfunction

  task automatic step;
    @(posedge CK);
    #1;
  endtask

  // Offer one pattern, follow it through to the result and release it after hold cycles of backpressure.
  task automatic run_pattern(input logic [19:0] p, input int hold, input bit clr);
    int n;
    int lat;
    logic [19:0] prev;
    logic [15:0] e_sig;
    prev = exp_chain;
    sig_clr = clr;
    pat_valid = 1'b1;
    pat_data = p;
    n = 0;
    while (!pat_ready && n < 50) begin
      step();
      n++;
    end
    vectors++;
    if (!pat_ready) begin
      $display("FAIL pat_ready_timeout: pat_ready=%0b required 1", pat_ready);
      errors++;
      pat_valid = 1'b0;
      return;
    end
    lat = 1;
    while (lat <= 40) begin
      step();
      if (res_valid) break;
      vectors++;
      if (lat <= 20) begin
        if (so !== prev[lat-1] || cone_valid !== 1'b0 || pat_ready !== 1'b0) begin
          $display("FAIL shift_cycle%0d: so=%0b cone_valid=%0b pat_ready=%0b required so=%0b 0 0",
                   lat, so, cone_valid, pat_ready, prev[lat-1]);
          errors++;
        end
      end else begin
        if (cone_valid !== 1'b1 || pat_ready !== 1'b0) begin
          $display("FAIL settle_capture%0d: cone_valid=%0b pat_ready=%0b required 1 0",
                   lat, cone_valid, pat_ready);
          errors++;
        end
      end
      // pattern traffic while busy must be ignored
      pat_valid = 1'($urandom_range(0, 1));
      pat_data = 20'($urandom);
      lat++;
    end
    pat_valid = 1'b0;
    vectors++;
    if (lat != 23) begin
      $display("FAIL latency: res_valid after %0d cycles required 23", lat);
      errors++;
      if (!res_valid) return;
    end

    exp_chain = p;
    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`ifdef S15850_N460_MISR_EN
    exp_sig = clr ? 16'h0000 : sig_model(exp_sig, ^p);
`else
    exp_sig = 16'h0000;
`endif
    exp_q.push_back({15'd0, ^p});
    e_sig = exp_sig;

    vectors++;
    if (res_bit !== exp_q[0][0] || state_q !== exp_chain || pat_cnt !== exp_cnt || sig !== e_sig
        || cone_valid !== 1'b1 || pat_ready !== 1'b0) begin
      $display("FAIL result: res_bit=%0b state_q=%05h pat_cnt=%0d sig=%04h cv=%0b pr=%0b required %0b %05h %0d %04h 1 0",
               res_bit, state_q, pat_cnt, sig, cone_valid, pat_ready, exp_q[0][0], exp_chain, exp_cnt, e_sig);
      errors++;
    end

    res_ready = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      step();
      vectors++;
      if (res_valid !== 1'b1 || res_bit !== exp_q[0][0] || state_q !== exp_chain || pat_ready !== 1'b0) begin
        $display("FAIL backpressure%0d: res_valid=%0b res_bit=%0b state_q=%05h pat_ready=%0b required 1 %0b %05h 0",
                 i, res_valid, res_bit, state_q, pat_ready, exp_q[0][0], exp_chain);
        errors++;
      end
      if (i == hold - 1) res_ready = 1'b1;
    end
    step();
    res_ready = 1'b0;
    sig_clr = 1'b0;
    void'(exp_q.pop_front());
    vectors++;
    if (res_valid !== 1'b0 || cone_valid !== 1'b0 || pat_ready !== 1'b1 || state_q !== exp_chain) begin
      $display("FAIL release: res_valid=%0b cone_valid=%0b pat_ready=%0b state_q=%05h required 0 0 1 %05h",
               res_valid, cone_valid, pat_ready, state_q, exp_chain);
      errors++;
    end
  endtask

  task automatic test_reset;
    int n;
    RST = 1'b1;
    pat_valid = 1'b0;
    pat_data = 20'h0;
    res_ready = 1'b0;
    sig_clr = 1'b0;
    repeat (3) step();
    vectors++;
    if (pat_ready !== 1'b0 || cone_valid !== 1'b0 || res_valid !== 1'b0 || state_q !== 20'h0
        || so !== 1'b0 || pat_cnt !== 16'h0 || sig !== 16'h0 || res_bit !== 1'b0) begin
      $display("FAIL reset_hold: pr=%0b cv=%0b rv=%0b state_q=%05h so=%0b cnt=%0d sig=%04h rb=%0b required all 0",
               pat_ready, cone_valid, res_valid, state_q, so, pat_cnt, sig, res_bit);
      errors++;
    end
    RST = 1'b0;
    step();
    vectors++;
    if (pat_ready !== 1'b1) begin
      $display("FAIL reset_release: pat_ready=%0b required 1", pat_ready);
      errors++;
    end
    exp_chain = 20'h0;
    exp_cnt = 16'h0;
    exp_sig = 16'h0;
    exp_q.delete();

    // load something, reset partway through the shift
    run_pattern(20'hFFFFF, 0, 1'b0);
    pat_valid = 1'b1;
    pat_data = 20'h5A5A5;
    n = 0;
    while (!pat_ready && n < 10) begin
      step();
      n++;
    end
    step();
    pat_valid = 1'b0;
    repeat (6) step();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    step();
    vectors++;
    if (state_q !== 20'h0 || pat_cnt !== 16'h0 || res_valid !== 1'b0 || pat_ready !== 1'b1
        || cone_valid !== 1'b0 || sig !== 16'h0 || so !== 1'b0) begin
      $display("FAIL reset_mid_shift: state_q=%05h cnt=%0d rv=%0b pr=%0b cv=%0b sig=%04h so=%0b required 0 0 0 1 0 0 0",
               state_q, pat_cnt, res_valid, pat_ready, cone_valid, sig, so);
      errors++;
    end
    exp_chain = 20'h0;
    exp_cnt = 16'h0;
    exp_sig = 16'h0;
  endtask

  task automatic test_directed;
    run_pattern(20'h00000, 0, 1'b0);
    run_pattern(20'h00001, 0, 1'b0);
    run_pattern(20'h00000, 0, 1'b0);
  endtask

  task automatic test_signature_sequence;
    RST = 1'b1;
    step();
    RST = 1'b0;
    step();
    exp_chain = 20'h0;
    exp_cnt = 16'h0;
    exp_sig = 16'h0;
    run_pattern(20'h00001, 0, 1'b0);
    run_pattern(20'h00000, 0, 1'b0);
    run_pattern(20'h00001, 0, 1'b0);
    vectors++;
`ifdef S15850_N460_MISR_EN
    if (sig !== 16'h0005 || pat_cnt !== 16'd3) begin
      $display("FAIL sig_sequence: sig=%04h pat_cnt=%0d required 0005 3", sig, pat_cnt);
      errors++;
    end
`else
    if (sig !== 16'h0000 || pat_cnt !== 16'd3) begin
      $display("FAIL sig_sequence: sig=%04h pat_cnt=%0d required 0000 3", sig, pat_cnt);
      errors++;
    end
`endif
    // idle clear
    sig_clr = 1'b1;
    step();
    sig_clr = 1'b0;
    exp_sig = 16'h0;
    vectors++;
    if (sig !== exp_sig) begin
      $display("FAIL sig_clr_idle: sig=%04h required %04h", sig, exp_sig);
      errors++;
    end
  endtask

  task automatic test_backpressure;
    run_pattern(20'h3C3C3, 10, 1'b0);
  endtask

  task automatic test_scan_out;
    run_pattern(20'hA5A5A, 0, 1'b0);
    run_pattern(20'h00000, 0, 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 30; i++) begin
      run_pattern(20'($urandom), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_signature_sequence();
    test_backpressure();
    test_scan_out();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // hard stop if something stalls the sequence
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

endmodule
